// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 data path: byte width, default sizing and
// the stream-xor control states.
package rc4_pkg;
   localparam int BYTE_W       = 8;
   localparam int DEF_LEN_W    = 16;
   localparam int DEF_KS_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/rc4_ks_fifo.sv
// Small synchronous keystream FIFO; pointers carry one extra bit so that
// full and empty can be told apart when the indices match.
module rc4_ks_fifo
   import rc4_pkg::*;
#(
   parameter int DEPTH = DEF_KS_DEPTH,
   parameter int W     = BYTE_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset: the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/rc4_stream_xor.sv
// Pairs each data byte with one buffered keystream byte and emits the XOR
// through a registered output stage; pulses done once the message is out.
module rc4_stream_xor
   import rc4_pkg::*;
#(
   parameter int KS_DEPTH = DEF_KS_DEPTH,
   parameter int LEN_W    = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  msg_length,
   input  logic [BYTE_W-1:0] ks_data,
   input  logic              ks_valid,
   output logic              ks_ready,
   input  logic [BYTE_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [BYTE_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              busy,
   output logic              done
);
   localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

   state_t            state, state_nxt;
   logic [LEN_W-1:0]  len_q, ks_cnt, in_cnt, out_cnt;
   logic              fifo_full, fifo_empty;
   logic [BYTE_W-1:0] fifo_head;
   logic              ks_xfer, din_xfer, dout_xfer;

   assign ks_xfer   = ks_valid && ks_ready;
   assign din_xfer  = din_valid && din_ready;
   assign dout_xfer = dout_valid && dout_ready;

   rc4_ks_fifo #(.DEPTH(KS_DEPTH), .W(BYTE_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ks_xfer),
      .wdata (ks_data),
      .pop   (din_xfer),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = (msg_length == '0) ? DONE : RUN;
         RUN:   if (in_cnt == len_q) state_nxt = FLUSH;
         FLUSH: if (out_cnt == len_q) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Keystream is only requested up to the message length, so any surplus
   // stays with the generator for the next message.
   always_comb begin
      ks_ready  = 1'b0;
      din_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         RUN: begin
            busy      = 1'b1;
            ks_ready  = !fifo_full && (ks_cnt < len_q);
            din_ready = !fifo_empty && (!dout_valid || dout_ready);
         end
         FLUSH: begin
            busy     = 1'b1;
            ks_ready = !fifo_full && (ks_cnt < len_q);
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q   <= '0;
         ks_cnt  <= '0;
         in_cnt  <= '0;
         out_cnt <= '0;
      end else if (state == IDLE && start) begin
         len_q   <= msg_length;
         ks_cnt  <= '0;
         in_cnt  <= '0;
         out_cnt <= '0;
      end else begin
         if (ks_xfer)   ks_cnt  <= ks_cnt + CNT_ONE;
         if (din_xfer)  in_cnt  <= in_cnt + CNT_ONE;
         if (dout_xfer) out_cnt <= out_cnt + CNT_ONE;
      end
   end

   // A new byte may replace one being accepted in the same cycle, which
   // keeps the output stage at one byte per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (din_xfer) begin
         dout       <= din ^ fifo_head;
         dout_valid <= 1'b1;
      end else if (dout_xfer) begin
         dout_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rc4_stream_xor.sv
// Directed bench for rc4_stream_xor using the "Plaintext" known vector.
module tb_rc4_stream_xor;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] msg_length = '0;
   logic [7:0]  ks_data = '0;
   logic        ks_valid = 1'b0;
   logic        ks_ready;
   logic [7:0]  din = '0;
   logic        din_valid = 1'b0;
   logic        din_ready;
   logic [7:0]  dout;
   logic        dout_valid;
   logic        dout_ready = 1'b0;
   logic        busy;
   logic        done;

   rc4_stream_xor dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .msg_length (msg_length),
      .ks_data    (ks_data),
      .ks_valid   (ks_valid),
      .ks_ready   (ks_ready),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] ks_vec  [10];
   logic [7:0] din_vec [10];
   logic [7:0] exp_vec [9];
   bit         bp_pat  [4];

   // results of the last run_msg
   logic [7:0] got [16];
   int n_out, ks_taken, din_taken, done_iter, last_out_iter;
   int stable_err, over_err, starve_idle, starve_bad, busy_mid;
   bit aborted;

   task automatic idle_cycles(input int n);
      start = 0; ks_valid = 0; din_valid = 0; dout_ready = 0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one message and records what the DUT did; the test tasks judge it.
   task automatic run_msg(input int len, input bit bp, input int gap_at,
                          input int restart_at, input int abort_at);
      int ks_i, din_i, gap_left;
      bit gap_used, prev_hold, fin, ks_x, d_x, o_x;
      logic [7:0] prev_dout;
      n_out = 0; done_iter = -1; last_out_iter = -1; stable_err = 0; over_err = 0;
      starve_idle = 0; starve_bad = 0; busy_mid = 0; aborted = 0;
      ks_i = 0; din_i = 0; gap_left = 0; gap_used = 0; prev_hold = 0; fin = 0;
      prev_dout = '0;
      start = 1; msg_length = 16'(len);
      ks_valid = 1; ks_data = ks_vec[0];
      din_valid = (len > 0); din = din_vec[0];
      dout_ready = bp ? bp_pat[0] : 1'b1;
      for (int it = 0; it < 300 && !fin; it++) begin
         @(negedge clk);
         ks_x = ks_valid && ks_ready;
         d_x  = din_valid && din_ready;
         o_x  = dout_valid && dout_ready;
         if (it == 1) busy_mid = int'(busy);
         if (prev_hold && (!dout_valid || dout !== prev_dout)) stable_err++;
         prev_hold = dout_valid && !dout_ready;
         prev_dout = dout;
         if (d_x && din_i >= ks_i) over_err++;
         if (gap_left > 0 && din_i == ks_i) begin
            starve_idle++;
            if (din_ready) starve_bad++;
         end
         if (o_x) begin
            if (n_out < 16) got[n_out] = dout;
            n_out++;
            last_out_iter = it;
         end
         if (done) begin done_iter = it; fin = 1; end
         @(posedge clk); #1;
         start = 0;
         if (it == restart_at) begin start = 1; msg_length = 16'd2; end
         if (ks_x) ks_i++;
         if (d_x) din_i++;
         if (gap_left > 0) gap_left--;
         if (!gap_used && gap_at > 0 && ks_i == gap_at) begin gap_left = 10; gap_used = 1; end
         ks_valid   = (gap_left == 0);
         ks_data    = (ks_i < 10) ? ks_vec[ks_i] : 8'h00;
         din_valid  = (din_i < len);
         din        = (din_i < 10) ? din_vec[din_i] : 8'h00;
         dout_ready = bp ? bp_pat[(it + 1) % 4] : 1'b1;
         if (abort_at > 0 && n_out == abort_at && !fin) begin rst = 1; aborted = 1; fin = 1; end
      end
      ks_taken = ks_i;
      din_taken = din_i;
   endtask

   task automatic test_reset;
      rst = 0; #1 rst = 1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (ks_ready !== 1'b0)   begin bad++; $display("FAIL rst_ks_ready got=%b want=0", ks_ready); end
      total++; if (din_ready !== 1'b0)  begin bad++; $display("FAIL rst_din_ready got=%b want=0", din_ready); end
      total++; if (dout !== 8'h00)      begin bad++; $display("FAIL rst_dout got=%h want=00", dout); end
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rst_dout_valid got=%b want=0", dout_valid); end
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0)       begin bad++; $display("FAIL rst_done got=%b want=0", done); end
      rst = 0;
      idle_cycles(2);
   endtask

   task automatic test_known_vector;
      run_msg(9, 0, 0, -1, 0);
      total++; if (busy_mid !== 1) begin bad++; $display("FAIL kv_busy got=%0d want=1", busy_mid); end
      total++; if (n_out !== 9) begin bad++; $display("FAIL kv_count got=%0d want=9", n_out); end
      for (int i = 0; i < 9; i++) begin
         total++; if (got[i] !== exp_vec[i]) begin bad++; $display("FAIL kv_byte%0d got=%h want=%h", i, got[i], exp_vec[i]); end
      end
      total++; if (ks_taken !== 9) begin bad++; $display("FAIL kv_ks_taken got=%0d want=9", ks_taken); end
      total++; if (done_iter !== last_out_iter + 2) begin bad++; $display("FAIL kv_done_time got=%0d want=%0d", done_iter, last_out_iter + 2); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL kv_done_width got=%b want=0", done); end
      idle_cycles(2);
   endtask

   task automatic test_backpressure;
      run_msg(9, 1, 0, -1, 0);
      total++; if (n_out !== 9) begin bad++; $display("FAIL bp_count got=%0d want=9", n_out); end
      for (int i = 0; i < 9; i++) begin
         total++; if (got[i] !== exp_vec[i]) begin bad++; $display("FAIL bp_byte%0d got=%h want=%h", i, got[i], exp_vec[i]); end
      end
      total++; if (stable_err !== 0) begin bad++; $display("FAIL bp_hold_stable got=%0d want=0", stable_err); end
      total++; if (done_iter !== last_out_iter + 2) begin bad++; $display("FAIL bp_done_time got=%0d want=%0d", done_iter, last_out_iter + 2); end
      idle_cycles(2);
   endtask

   task automatic test_starvation;
      run_msg(9, 0, 4, -1, 0);
      total++; if (starve_idle < 8) begin bad++; $display("FAIL st_window got=%0d want>=8", starve_idle); end
      total++; if (starve_bad !== 0) begin bad++; $display("FAIL st_din_ready got=%0d want=0", starve_bad); end
      total++; if (over_err !== 0) begin bad++; $display("FAIL st_overrun got=%0d want=0", over_err); end
      total++; if (n_out !== 9) begin bad++; $display("FAIL st_count got=%0d want=9", n_out); end
      for (int i = 0; i < 9; i++) begin
         total++; if (got[i] !== exp_vec[i]) begin bad++; $display("FAIL st_byte%0d got=%h want=%h", i, got[i], exp_vec[i]); end
      end
      idle_cycles(2);
   endtask

   task automatic test_length_bound;
      run_msg(3, 0, 0, -1, 0);
      total++; if (ks_taken !== 3) begin bad++; $display("FAIL lb_ks_taken got=%0d want=3", ks_taken); end
      total++; if (n_out !== 3) begin bad++; $display("FAIL lb_count got=%0d want=3", n_out); end
      for (int i = 0; i < 3; i++) begin
         total++; if (got[i] !== exp_vec[i]) begin bad++; $display("FAIL lb_byte%0d got=%h want=%h", i, got[i], exp_vec[i]); end
      end
      idle_cycles(2);
   endtask

   task automatic test_zero_length;
      run_msg(0, 0, 0, -1, 0);
      total++; if (done_iter < 1 || done_iter > 2) begin bad++; $display("FAIL zl_done_time got=%0d want=1..2", done_iter); end
      total++; if (ks_taken !== 0) begin bad++; $display("FAIL zl_ks_taken got=%0d want=0", ks_taken); end
      total++; if (din_taken !== 0 || n_out !== 0) begin bad++; $display("FAIL zl_data got=%0d/%0d want=0/0", din_taken, n_out); end
      idle_cycles(2);
   endtask

   task automatic test_ignored_start;
      run_msg(9, 0, 0, 3, 0);
      total++; if (n_out !== 9) begin bad++; $display("FAIL is_count got=%0d want=9", n_out); end
      total++; if (ks_taken !== 9) begin bad++; $display("FAIL is_ks_taken got=%0d want=9", ks_taken); end
      for (int i = 0; i < 9; i++) begin
         total++; if (got[i] !== exp_vec[i]) begin bad++; $display("FAIL is_byte%0d got=%h want=%h", i, got[i], exp_vec[i]); end
      end
      idle_cycles(2);
   endtask

   task automatic test_reset_mid;
      int done_seen;
      run_msg(9, 0, 0, -1, 4);
      total++; if (aborted !== 1'b1) begin bad++; $display("FAIL rm_abort_reached got=%b want=1", aborted); end
      #1;
      total++; if (dout_valid !== 1'b0 || dout !== 8'h00) begin bad++; $display("FAIL rm_dout got=%b/%h want=0/00", dout_valid, dout); end
      total++; if (busy !== 1'b0 || ks_ready !== 1'b0 || din_ready !== 1'b0) begin bad++; $display("FAIL rm_ctrl got=%b%b%b want=000", busy, ks_ready, din_ready); end
      done_seen = 0;
      start = 0; ks_valid = 0; din_valid = 0; dout_ready = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      total++; if (done_seen !== 0) begin bad++; $display("FAIL rm_no_done got=%0d want=0", done_seen); end
      @(posedge clk); #1;
      run_msg(9, 0, 0, -1, 0);
      total++; if (n_out !== 9) begin bad++; $display("FAIL rm_count got=%0d want=9", n_out); end
      for (int i = 0; i < 9; i++) begin
         total++; if (got[i] !== exp_vec[i]) begin bad++; $display("FAIL rm_byte%0d got=%h want=%h", i, got[i], exp_vec[i]); end
      end
      idle_cycles(2);
   endtask

   initial begin
      ks_vec  = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h55};
      din_vec = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3, 8'h00};
      exp_vec = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
      bp_pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
      test_reset;
      test_known_vector;
      test_backpressure;
      test_starvation;
      test_length_bound;
      test_zero_length;
      test_ignored_start;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rc4_stream_xor.md
Name: rc4_stream_xor

Overview:
- Data-path consumer of the RC4 keystream generator: turns a keystream byte stream into a ciphertext-to-plaintext stream. The same block also encrypts, since RC4 is symmetric.
- Sits downstream of the keystream generator and upstream of the byte sink.
- Takes a message length on `start` and pairs each data byte with exactly one keystream byte.
- Buffers keystream in a small FIFO, registers the output, and pulses `done` after the last byte has been delivered.

Parameters:
- KS_DEPTH, 4, keystream FIFO depth in bytes. Must be a power of 2, ≥2.
- LEN_W, 16, width of the message-length and byte counters.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; latches msg_length; honoured only in IDLE
- msg_length  input  LEN_W  number of bytes in the message
- ks_data  input  8  keystream byte from the generator
- ks_valid  input  1  ks_data valid
- ks_ready  output  1  block accepts a keystream byte this cycle
- din  input  8  cipher (or plain) input byte
- din_valid  input  1  din valid
- din_ready  output  1  block accepts din this cycle
- dout  output  8  din XOR keystream byte
- dout_valid  output  1  dout valid
- dout_ready  input  1  sink accepts dout
- busy  output  1  high in RUN or FLUSH
- done  output  1  one-cycle pulse when the message is complete

Behaviour:
- Reset values: ks_ready=0, din_ready=0, dout=8'h00, dout_valid=0, busy=0, done=0. FIFO is emptied and all counters are cleared. State is IDLE.
- Handshakes:
  - Transfer occurs on any rising edge where valid && ready.
  - Valid is not withdrawn until the transfer occurs; ready may toggle freely.
- States:
  - IDLE:
    - `start` latches msg_length into len_q and clears ks_cnt, in_cnt and out_cnt.
    - If msg_length==0, go to DONE; otherwise go to RUN.
  - RUN: byte processing, per the rules below.
    - When in_cnt reaches len_q, go to FLUSH.
  - FLUSH: wait until out_cnt==len_q, i.e. the last dout has been accepted, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Keystream side (RUN and FLUSH):
  - ks_ready = !fifo_full && (ks_cnt < len_q).
  - Never requests more keystream than the message needs, so no surplus keystream is lost.
  - Surplus keystream stays with the generator for the next message.
- Data side:
  - din_ready = RUN && !fifo_empty && (!dout_valid || dout_ready).
  - On a din transfer:
    - dout <= din ^ fifo_head and the FIFO is popped.
    - dout_valid <= 1; in_cnt increments.
  - On dout transfer with no new din: dout_valid <= 0; out_cnt increments.
  - Simultaneous dout accept and din accept in one cycle: dout is replaced and dout_valid stays 1, giving full throughput of 1 byte/cycle.
- Latency: din transfer to dout_valid is 1 cycle.
- FIFO:
  - Simultaneous push and pop when full: not possible, because ks_ready=0.
  - Simultaneous push and pop when empty: not possible, because din_ready=0.
  - Push and pop at the same time at other levels: level is unchanged.
  - Pointers wrap modulo KS_DEPTH; full/empty are tracked with an extra pointer bit.
- `start` in RUN, FLUSH or DONE is ignored.
- Counters are LEN_W bits with no wrap; the maximum message is 2^LEN_W−1 bytes.
- Reset mid-message: everything aborts at once. No done is issued. Partial FIFO contents are discarded.

Decomposition:
- Shared package rc4_pkg:
  - state enum {IDLE, RUN, FLUSH, DONE}.
  - Default LEN_W and KS_DEPTH constants.
  - The BYTE_W=8 constant shared with the keystream generator.
- One sub-module, rc4_ks_fifo:
  - Parameterised synchronous FIFO with push, pop, full, empty and head data.
  - Uses the same clk and rst.
- XOR, control FSM and counters live in rc4_stream_xor.

Test Plan:
- Known vector:
  - Stimulus: msg_length=9; ks = EB 9F 77 81 B7 34 CA 72 A7; din = BB F3 16 E8 D9 40 AF 0A D3; dout_ready=1.
  - Response: dout = 50 6C 61 69 6E 74 65 78 74 ("Plaintext"); done 1 cycle after the last dout accept; exactly 9 ks bytes consumed.
- Back-pressure:
  - Stimulus: same vector with dout_ready toggling 1,0,0,1.
  - Response: dout sequence identical; no byte dropped or duplicated; dout held stable while dout_ready=0.
- Keystream starvation:
  - Stimulus: ks_valid held 0 for 10 cycles mid-message.
  - Response: din_ready=0 throughout that window; the message completes correctly after ks resumes.
- Length bound:
  - Stimulus: msg_length=3 with ks_valid held 1 throughout.
  - Response: ks_ready drops after 3 accepted bytes; 4th keystream byte not consumed.
- Zero length and ignored start:
  - Stimulus (a): msg_length=0.
  - Response (a): done asserted 2 cycles after start; no handshakes.
  - Stimulus (b): `start` pulsed again during RUN.
  - Response (b): no effect on len_q.
- Reset mid-message:
  - Stimulus: rst asserted after 4 of 9 bytes.
  - Response: all outputs return to reset values asynchronously; no done; a new start with the full vector then gives the correct output.
